// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared FSM encoding, result-flag indices and sizing helper for seq_magnitude_comparator
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int FLAG_EQ = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 2;
  localparam int FLAG_W  = 3;

  // A single-beat compare still carries a one-bit counter so the datapath stays uniform
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational compare of one operand chunk pair
// SIGNED_CMP_EN: the MSB chunk treats its top bit as a two's-complement sign.
module chunk_cmp #(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               is_msb,
  output logic               c_eq,
  output logic               c_gt
);

  always_comb begin
    c_eq = (a == b);
`ifdef SIGNED_CMP_EN
    // Differing signs decide outright; equal signs order correctly as unsigned
    if (is_msb && (a[CHUNK_W-1] != b[CHUNK_W-1])) begin
      c_gt = b[CHUNK_W-1];
    end else begin
      c_gt = (a > b);
    end
`else
    c_gt = (a > b);
`endif
  end

`ifndef SIGNED_CMP_EN
  logic unused_is_msb;
  assign unused_is_msb = is_msb;
`endif

endmodule

// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - MSB-first streamed A/B magnitude compare with registered eq/gt/lt handshake
// SIGNED_CMP_EN selects two's-complement ordering of the full operand (handled inside chunk_cmp).
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int CHUNK_W    = 4,
  parameter int NUM_CHUNKS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_a,
  input  logic [CHUNK_W-1:0] in_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  localparam int              CNT_W    = cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               decided_q, decided_d;
  logic               gt_r_q, gt_r_d;
  logic               lt_r_q, lt_r_d;
  logic               res_valid_q, res_valid_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;

  logic beat;
  logic is_msb;
  logic last_beat;
  logic c_eq;
  logic c_gt;
  logic dec_next;
  logic gt_next;
  logic lt_next;

  assign in_ready  = (state_q != ST_DONE);
  assign beat      = in_valid & in_ready;
  assign is_msb    = (cnt_q == '0);
  assign last_beat = (cnt_q == LAST_IDX);

  chunk_cmp #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_cmp (
    .a      (in_a),
    .b      (in_b),
    .is_msb (is_msb),
    .c_eq   (c_eq),
    .c_gt   (c_gt)
  );

  // The first differing chunk (MSB first) fixes the ordering; later chunks only advance the count
  always_comb begin
    dec_next = decided_q;
    gt_next  = gt_r_q;
    lt_next  = lt_r_q;
    if (beat && !decided_q && !c_eq) begin
      dec_next = 1'b1;
      gt_next  = c_gt;
      lt_next  = !c_gt;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    decided_d   = decided_q;
    gt_r_d      = gt_r_q;
    lt_r_d      = lt_r_q;
    res_valid_d = res_valid_q;
    flags_d     = flags_q;

    if (clr) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      decided_d   = 1'b0;
      gt_r_d      = 1'b0;
      lt_r_d      = 1'b0;
      res_valid_d = 1'b0;
      flags_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COMPARE: begin
          if (beat) begin
            if (last_beat) begin
              // Latches are rearmed here so the next compare starts undecided
              state_d          = ST_DONE;
              cnt_d            = '0;
              decided_d        = 1'b0;
              gt_r_d           = 1'b0;
              lt_r_d           = 1'b0;
              res_valid_d      = 1'b1;
              flags_d[FLAG_EQ] = !dec_next;
              flags_d[FLAG_GT] = gt_next;
              flags_d[FLAG_LT] = lt_next;
            end else begin
              state_d   = ST_COMPARE;
              cnt_d     = cnt_q + CNT_W'(1);
              decided_d = dec_next;
              gt_r_d    = gt_next;
              lt_r_d    = lt_next;
            end
          end
        end
        ST_DONE: begin
          if (res_valid_q && res_ready) begin
            state_d     = ST_IDLE;
            res_valid_d = 1'b0;
            flags_d     = '0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          decided_d   = 1'b0;
          gt_r_d      = 1'b0;
          lt_r_d      = 1'b0;
          res_valid_d = 1'b0;
          flags_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      decided_q   <= 1'b0;
      gt_r_q      <= 1'b0;
      lt_r_q      <= 1'b0;
      res_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      decided_q   <= decided_d;
      gt_r_q      <= gt_r_d;
      lt_r_q      <= lt_r_d;
      res_valid_q <= res_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign res_valid = res_valid_q;
  assign eq        = flags_q[FLAG_EQ];
  assign gt        = flags_q[FLAG_GT];
  assign lt        = flags_q[FLAG_LT];

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - self-checking bench for seq_magnitude_comparator (SIGNED_CMP_EN aware)
module tb_seq_magnitude_comparator;

  localparam int CW = 4;
  localparam int NC = 2;
  localparam int W  = CW * NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [CW-1:0] in_a = '0;
  logic [CW-1:0] in_b = '0;
  logic          in_ready, res_valid, eq, gt, lt;

  logic          s_clr = 1'b0;
  logic          s_in_valid = 1'b0;
  logic          s_res_ready = 1'b0;
  logic [CW-1:0] s_a = '0;
  logic [CW-1:0] s_b = '0;
  logic          s_in_ready, s_res_valid, s_eq, s_gt, s_lt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
    .eq(eq), .gt(gt), .lt(lt)
  );

  seq_magnitude_comparator #(.CHUNK_W(CW), .NUM_CHUNKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_a), .in_b(s_b), .res_valid(s_res_valid), .res_ready(s_res_ready),
    .eq(s_eq), .gt(s_gt), .lt(s_lt)
  );

  // Reference: whole-operand ordering; 0 = equal, 1 = A greater, 2 = A less
  function automatic int ref_cmp(input logic [63:0] a, input logic [63:0] b, input int w);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
`ifdef SIGNED_CMP_EN
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
    if (sa == sb) return 0;
    return (sa > sb) ? 1 : 2;
  endfunction

  function automatic logic [2:0] exp_flags(input int code);
    case (code)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [CW-1:0] chunk_of(input logic [W-1:0] v, input int k);
    return CW'(v >> (CW * (NC - 1 - k)));
  endfunction

  task automatic push_beat(input logic [CW-1:0] a, input logic [CW-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_err++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = CW'($urandom);
    in_b = CW'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap,
                        input int hold, input bit rnd, input string tag);
    logic [2:0] exp;
    int g, h;
    exp = exp_flags(ref_cmp(64'(a), 64'(b), W));
    res_ready = 1'b0;
    for (int k = 0; k < NC; k++) begin
      g = rnd ? int'($urandom_range(0, gap)) : ((k == 0) ? 0 : gap);
      repeat (g) @(negedge clk);
      push_beat(chunk_of(a, k), chunk_of(b, k));
    end
    n_cmp++;
    if (res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s latency: res_valid=%b required 1 one cycle after last beat", tag, res_valid);
    end
    n_cmp++;
    if ({eq, gt, lt} !== exp) begin
      n_err++;
      $display("FAIL %s flags: a=%h b=%h eq/gt/lt=%b required %b", tag, a, b, {eq, gt, lt}, exp);
    end
    h = rnd ? int'($urandom_range(0, hold)) : hold;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      n_cmp++;
      if (res_valid !== 1'b1 || {eq, gt, lt} !== exp || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold: res_valid=%b flags=%b in_ready=%b required 1/%b/0",
                 tag, res_valid, {eq, gt, lt}, in_ready, exp);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || {eq, gt, lt} !== 3'b000 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s taken: res_valid=%b flags=%b in_ready=%b required 0/000/1",
               tag, res_valid, {eq, gt, lt}, in_ready);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({res_valid, eq, gt, lt, s_res_valid, s_eq, s_gt, s_lt} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {res_valid, eq, gt, lt, s_res_valid, s_eq, s_gt, s_lt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b%b required 11", in_ready, s_in_ready);
    end
  endtask

  task automatic test_equal_back_to_back;
    run_op(8'h3C, 8'h3C, 0, 0, 1'b0, "eq_3c");
  endtask

  task automatic test_decided_sticky;
    run_op(8'h5A, 8'h4F, 0, 0, 1'b0, "gt_5a_4f");
    run_op(8'h12, 8'h1F, 0, 0, 1'b0, "lt_12_1f");
  endtask

  task automatic test_stalls;
    run_op(8'h5A, 8'h4F, 3, 4, 1'b0, "stall_gt");
    run_op(8'h12, 8'h1F, 3, 4, 1'b0, "stall_lt");
  endtask

  task automatic test_reset_abort;
    push_beat(4'hF, 4'h0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, eq, gt, lt} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_abort_outputs: got %b required 0000", {res_valid, eq, gt, lt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h00, 8'h01, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_clr_abort;
    push_beat(4'hF, 4'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_abort_state: res_valid=%b in_ready=%b required 0/1", res_valid, in_ready);
    end
    run_op(8'h00, 8'h01, 0, 0, 1'b0, "after_clr");
  endtask

  task automatic test_clr_with_beat;
    clr = 1'b1;
    in_valid = 1'b1;
    in_a = 4'hF;
    in_b = 4'h0;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    run_op(8'h00, 8'h01, 0, 0, 1'b0, "clr_wins");
  endtask

  task automatic test_clr_in_done;
    res_ready = 1'b0;
    push_beat(4'h3, 4'h3);
    push_beat(4'hC, 4'hC);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if ({res_valid, eq, gt, lt} !== 4'b0000 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_in_done: got %b in_ready=%b required 0000/1", {res_valid, eq, gt, lt}, in_ready);
    end
  endtask

  task automatic test_signed_msb;
    logic [2:0] exp;
`ifdef SIGNED_CMP_EN
    exp = 3'b001;
`else
    exp = 3'b010;
`endif
    res_ready = 1'b0;
    push_beat(4'h8, 4'h0);
    push_beat(4'h0, 4'h1);
    n_cmp++;
    if ({eq, gt, lt} !== exp) begin
      n_err++;
      $display("FAIL signed_80_01: eq/gt/lt=%b required %b", {eq, gt, lt}, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_single_chunk;
    logic [CW-1:0] a, b;
    logic [2:0] exp;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0:       begin a = 4'h7; b = 4'h7; end
        1:       begin a = 4'h3; b = 4'h9; end
        2:       begin a = 4'h9; b = 4'h3; end
        default: begin a = CW'($urandom); b = CW'($urandom); end
      endcase
      exp = exp_flags(ref_cmp(64'(a), 64'(b), CW));
      s_in_valid = 1'b1;
      s_a = a;
      s_b = b;
      @(negedge clk);
      s_in_valid = 1'b0;
      n_cmp++;
      if (s_res_valid !== 1'b1 || {s_eq, s_gt, s_lt} !== exp) begin
        n_err++;
        $display("FAIL single_chunk a=%h b=%h: res_valid=%b flags=%b required 1/%b",
                 a, b, s_res_valid, {s_eq, s_gt, s_lt}, exp);
      end
      s_res_ready = 1'b1;
      @(negedge clk);
      s_res_ready = 1'b0;
      n_cmp++;
      if (s_res_valid !== 1'b0 || s_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL single_chunk_taken: res_valid=%b in_ready=%b required 0/1", s_res_valid, s_in_ready);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = {chunk_of(a, 0), CW'($urandom)};
        default: b = W'($urandom);
      endcase
      run_op(a, b, 2, 3, 1'b1, "random");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_equal_back_to_back;
    test_decided_sticky;
    test_stalls;
    test_reset_abort;
    test_clr_abort;
    test_clr_with_beat;
    test_clr_in_done;
    test_signed_msb;
    test_single_chunk;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
